// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DATA_BITS payload, optional even/odd parity,
// one or two stop bits, valid/ready word handshake with a registered serial line.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 234,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_done,
    output logic                 uart_tx
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

    if ((DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
        ((STOP_BITS != 1) && (STOP_BITS != 2)) || (CLKS_PER_BIT < 2)) begin : g_param_check
        $error("uart_tx_cfg: illegal parameter value");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t                 state, state_next;
    logic [CNT_W-1:0]       baud_cnt, baud_next;
    logic [3:0]             bit_cnt, bit_next;
    logic [DATA_BITS-1:0]   shift_reg, shift_next;
    logic                   parity_bit, parity_next;
    logic                   tx_reg, tx_next;
    logic                   ready_reg, ready_next;
    logic                   done_reg, done_next;
    logic                   bit_end;

    assign bit_end  = (baud_cnt == CNT_LAST);
    assign uart_tx  = tx_reg;
    assign tx_ready = ready_reg;
    assign tx_done  = done_reg;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_reg     <= 1'b1;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_next;
            bit_cnt    <= bit_next;
            shift_reg  <= shift_next;
            parity_bit <= parity_next;
            tx_reg     <= tx_next;
            ready_reg  <= ready_next;
            done_reg   <= done_next;
        end
    end

    // Every output is computed here one cycle ahead, so all ports come straight from flops.
    always_comb begin
        state_next  = state;
        baud_next   = bit_end ? '0 : baud_cnt + 1'b1;
        bit_next    = bit_cnt;
        shift_next  = shift_reg;
        parity_next = parity_bit;
        tx_next     = tx_reg;
        ready_next  = ready_reg;
        done_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                baud_next  = '0;
                tx_next    = 1'b1;
                ready_next = 1'b1;
                if (tx_valid && ready_reg) begin
                    shift_next  = tx_data;
                    parity_next = (PARITY == 2) ? ~^tx_data : ^tx_data;
                    state_next  = ST_START;
                    ready_next  = 1'b0;
                    tx_next     = 1'b0;
                    bit_next    = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                    tx_next    = shift_reg[0];
                    shift_next = shift_reg >> 1;
                    bit_next   = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == DATA_LAST) begin
                        bit_next = '0;
                        if (PARITY != 0) begin
                            state_next = ST_PARITY;
                            tx_next    = parity_bit;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        bit_next   = bit_cnt + 1'b1;
                        tx_next    = shift_reg[0];
                        shift_next = shift_reg >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                    tx_next    = 1'b1;
                    bit_next   = '0;
                end
            end
            ST_STOP: begin
                tx_next = 1'b1;
                if (bit_end) begin
                    if (bit_cnt == STOP_LAST) begin
                        state_next = ST_IDLE;
                        ready_next = 1'b1;
                        done_next  = 1'b1;
                        bit_next   = '0;
                    end else begin
                        bit_next = bit_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                tx_next    = 1'b1;
                ready_next = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: five instances (8N1, 8E1, 8O1, 7N1, 8N2,
// all 4 clocks per bit) share one stimulus; each vector checks one instance cycle by cycle.
module tb_uart_tx_cfg;

    localparam int CLKS = 4;
    localparam int NDUT = 5;

    logic            sys_clk;
    logic            rst;
    logic            tx_valid;
    logic [7:0]      tx_data;
    logic [NDUT-1:0] uart_v;
    logic [NDUT-1:0] ready_v;
    logic [NDUT-1:0] done_v;

    int checks;
    int errors;
    int cyc;
    int done_cnt0;
    int fall_q[$];
    logic prev_tx0;

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [15:0] frame;
        int          nb;
        bit          glitch;
    } vec_t;

    vec_t vecs[9];

    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_v[0]), .tx_done(done_v[0]), .uart_tx(uart_v[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_v[1]), .tx_done(done_v[1]), .uart_tx(uart_v[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_v[2]), .tx_done(done_v[2]), .uart_tx(uart_v[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
        .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data[6:0]),
        .tx_ready(ready_v[3]), .tx_done(done_v[3]), .uart_tx(uart_v[3]));
    uart_tx_cfg #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .sys_clk(sys_clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(ready_v[4]), .tx_done(done_v[4]), .uart_tx(uart_v[4]));

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Falling edges of the 8N1 line and its tx_done pulses, sampled mid-cycle.
    always @(negedge sys_clk) begin
        if (done_v[0]) done_cnt0 = done_cnt0 + 1;
        if (prev_tx0 && !uart_v[0]) fall_q.push_back(cyc);
        prev_tx0 = uart_v[0];
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic waitAllReady();
        int n = 0;
        while (ready_v !== {NDUT{1'b1}} && n < 200) begin
            @(posedge sys_clk); #1;
            n++;
        end
        checks = checks + 1;
        if (ready_v !== {NDUT{1'b1}}) begin
            errors = errors + 1;
            $display("[TB] FAIL wait_ready: got %b, expected %b", ready_v, {NDUT{1'b1}});
        end
    endtask

    // Checks cycles from..upto-1 of a frame; caller sits #1 after the edge of cycle 'from'.
    task automatic checkCycles(input int d, input logic [15:0] frame, input int from,
                               input int upto, input bit glitch, input logic [7:0] data);
        for (int j = from; j < upto; j++) begin
            checkOutput($sformatf("dut%0d uart c%0d", d, j), uart_v[d], frame[j / CLKS]);
            checkOutput($sformatf("dut%0d ready c%0d", d, j), ready_v[d], 1'b0);
            checkOutput($sformatf("dut%0d done c%0d", d, j), done_v[d], 1'b0);
            if (glitch && j == 10) begin
                tx_data  = ~data;
                tx_valid = 1'b1;
            end
            if (glitch && j == 11) tx_valid = 1'b0;
            @(posedge sys_clk); #1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        waitAllReady();
        @(negedge sys_clk);
        tx_data  = v.data;
        tx_valid = 1'b1;
        @(posedge sys_clk); #1;
        tx_valid = 1'b0;
        checkCycles(v.dut, v.frame, 0, v.nb * CLKS, v.glitch, v.data);
        checkOutput($sformatf("dut%0d end done", v.dut), done_v[v.dut], 1'b1);
        checkOutput($sformatf("dut%0d end ready", v.dut), ready_v[v.dut], 1'b1);
        checkOutput($sformatf("dut%0d end uart", v.dut), uart_v[v.dut], 1'b1);
        @(posedge sys_clk); #1;
        checkOutput($sformatf("dut%0d done drop", v.dut), done_v[v.dut], 1'b0);
        checkOutput($sformatf("dut%0d idle ready", v.dut), ready_v[v.dut], 1'b1);
        checkOutput($sformatf("dut%0d idle uart", v.dut), uart_v[v.dut], 1'b1);
    endtask

    initial begin
        vec_t v;
        int   dc;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        done_cnt0 = 0;
        prev_tx0  = 1'b1;
        rst       = 1'b1;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;

        // Frames are {stop bits, [parity], data, start}, bit 0 transmitted first.
        vecs[0] = '{0, 8'hA5, 16'({1'b1, 8'hA5, 1'b0}), 10, 1'b0};
        vecs[1] = '{1, 8'h07, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 1'b0};
        vecs[2] = '{2, 8'h07, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 1'b0};
        vecs[3] = '{3, 8'h7F, 16'({1'b1, 7'h7F, 1'b0}), 9, 1'b0};
        vecs[4] = '{4, 8'hA5, 16'({2'b11, 8'hA5, 1'b0}), 11, 1'b0};
        vecs[5] = '{1, 8'hA5, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, 1'b0};
        vecs[6] = '{2, 8'h00, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11, 1'b0};
        vecs[7] = '{3, 8'h55, 16'({1'b1, 7'h55, 1'b0}), 9, 1'b0};
        vecs[8] = '{0, 8'h3C, 16'({1'b1, 8'h3C, 1'b0}), 10, 1'b1};

        repeat (3) @(posedge sys_clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            checkOutput($sformatf("reset uart%0d", i), uart_v[i], 1'b1);
            checkOutput($sformatf("reset ready%0d", i), ready_v[i], 1'b1);
            checkOutput($sformatf("reset done%0d", i), done_v[i], 1'b0);
        end
        @(negedge sys_clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Back-to-back frames with tx_valid held: 0x00 then 0xFF on the 8N1 instance.
        waitAllReady();
        fall_q.delete();
        dc = done_cnt0;
        @(negedge sys_clk);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge sys_clk); #1;
        checkCycles(0, 16'({1'b1, 8'h00, 1'b0}), 0, 10 * CLKS, 1'b0, 8'h00);
        checkOutput("b2b first done", done_v[0], 1'b1);
        checkOutput("b2b first ready", ready_v[0], 1'b1);
        checkOutput("b2b gap uart", uart_v[0], 1'b1);
        tx_data = 8'hFF;
        @(posedge sys_clk); #1;
        tx_valid = 1'b0;
        checkCycles(0, 16'({1'b1, 8'hFF, 1'b0}), 0, 10 * CLKS, 1'b0, 8'hFF);
        checkOutput("b2b second done", done_v[0], 1'b1);
        @(posedge sys_clk); #1;
        checkInt("b2b done pulses", done_cnt0 - dc, 2);
        checkInt("b2b falling edges", fall_q.size(), 2);
        if (fall_q.size() == 2) checkInt("b2b start spacing", fall_q[1] - fall_q[0], 10 * CLKS + 1);

        // Reset during data bit 3 (frame bit 4), then a clean frame.
        waitAllReady();
        dc = done_cnt0;
        @(negedge sys_clk);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        @(posedge sys_clk); #1;
        tx_valid = 1'b0;
        checkCycles(0, 16'({1'b1, 8'h5A, 1'b0}), 0, 17, 1'b0, 8'h5A);
        checkOutput("pre-reset uart bit3", uart_v[0], 1'b1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async reset uart", uart_v[0], 1'b1);
        checkOutput("async reset ready", ready_v[0], 1'b1);
        checkOutput("async reset done", done_v[0], 1'b0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        repeat (50) @(posedge sys_clk);
        #1;
        checkInt("reset no done", done_cnt0 - dc, 0);
        checkOutput("reset idle uart", uart_v[0], 1'b1);
        v = '{0, 8'hC3, 16'({1'b1, 8'hC3, 1'b0}), 10, 1'b0};
        applyStimulus(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
